// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Far-end data-memory responder for the MEM-stage load/store interface.
//   Accepts one request at a time, inserts WAIT_CYCLES wait states, then
//   completes with a one-cycle ack. Storage is DEPTH 32-bit words with
//   little-endian byte lanes. An out-of-range address or an empty lane mask
//   is acked with mem_err_o = 1, writes nothing and returns a zero word.
//
//   state  | meaning
//   S_IDLE | no request outstanding; samples mem_ce_i
//   S_WAIT | request captured, counting down wait states
//   S_RESP | ack cycle; always returns to S_IDLE
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   mem_ce_i    request valid, held until ack
//   mem_we_i    1 = store, 0 = load
//   mem_addr_i  byte address, bits [1:0] ignored
//   mem_sel_i   byte-lane enables
//   mem_data_i  store data
//   mem_data_o  load data, held between acks
//   mem_ack_o   one-cycle completion pulse
//   mem_err_o   error flag, valid with ack
//   stallreq_o  mem_ce_i & ~mem_ack_o
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        req_we;
  logic [29:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_data;

  logic [31:0] mem [DEPTH];

  logic              cur_we;
  logic [29:0]       cur_addr;
  logic [3:0]        cur_sel;
  logic [31:0]       cur_data;
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_err;
  logic              enter_resp;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^mem_addr_i[1:0];

  // With zero wait states the accept edge is also the edge entering RESP,
  // so the live inputs must be used instead of the not-yet-captured copy.
  always_comb begin
    if (state == S_IDLE) begin
      cur_we   = mem_we_i;
      cur_addr = mem_addr_i[31:2];
      cur_sel  = mem_sel_i;
      cur_data = mem_data_i;
    end else begin
      cur_we   = req_we;
      cur_addr = req_addr;
      cur_sel  = req_sel;
      cur_data = req_data;
    end
  end

  assign cur_idx = cur_addr[ADDR_W-1:0];
  assign cur_err = (|cur_addr[29:ADDR_W]) | (cur_sel == 4'b0000);

  always_comb begin
    enter_resp = 1'b0;
    case (state)
      S_IDLE:  enter_resp = mem_ce_i && (WAIT_CYCLES == 0);
      S_WAIT:  enter_resp = mem_ce_i && (cnt == 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  assign stallreq_o = mem_ce_i & ~mem_ack_o;

  // Storage is never cleared; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_we && !cur_err) begin
      for (int n = 0; n < 4; n++) begin
        if (cur_sel[n]) mem[cur_idx][8*n +: 8] <= cur_data[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_sel    <= '0;
      req_data   <= '0;
      mem_data_o <= 32'h0000_0000;
      mem_ack_o  <= 1'b0;
      mem_err_o  <= 1'b0;
    end else begin
      mem_ack_o <= 1'b0;
      mem_err_o <= 1'b0;
      if (state == S_IDLE && mem_ce_i) begin
        req_we   <= mem_we_i;
        req_addr <= mem_addr_i[31:2];
        req_sel  <= mem_sel_i;
        req_data <= mem_data_i;
        cnt      <= WAIT_LD;
      end
      if (enter_resp) begin
        state     <= S_RESP;
        mem_ack_o <= 1'b1;
        mem_err_o <= cur_err;
        if (cur_err)      mem_data_o <= 32'h0000_0000;
        else if (!cur_we) mem_data_o <= mem[cur_idx];
      end else begin
        case (state)
          S_IDLE: if (mem_ce_i) state <= S_WAIT;
          S_WAIT: begin
            if (!mem_ce_i) begin
              state <= S_IDLE;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
